// File: rtl/gray_step_arbiter_pkg.sv
// gray_step_arbiter_pkg
// Shared definitions for the Gray step arbiter and its counter:
//   - state_t     : arbiter FSM encoding (IDLE/CLEAR/RUN/DONE, 2 bits)
//   - GRAY_0..7   : the 3-bit Gray sequence in step order
//   - GRAY_WRAP   : value whose next step wraps to GRAY_0 (sets Overflow)
//   - gray_next() : one step along the sequence
package gray_step_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] GRAY_0 = 3'b000;
  localparam logic [2:0] GRAY_1 = 3'b001;
  localparam logic [2:0] GRAY_2 = 3'b011;
  localparam logic [2:0] GRAY_3 = 3'b010;
  localparam logic [2:0] GRAY_4 = 3'b110;
  localparam logic [2:0] GRAY_5 = 3'b111;
  localparam logic [2:0] GRAY_6 = 3'b101;
  localparam logic [2:0] GRAY_7 = 3'b100;

  localparam logic [2:0] GRAY_WRAP = GRAY_7;

  function automatic logic [2:0] gray_next(input logic [2:0] g);
    logic [2:0] n;
    case (g)
      GRAY_0:  n = GRAY_1;
      GRAY_1:  n = GRAY_2;
      GRAY_2:  n = GRAY_3;
      GRAY_3:  n = GRAY_4;
      GRAY_4:  n = GRAY_5;
      GRAY_5:  n = GRAY_6;
      GRAY_6:  n = GRAY_7;
      default: n = GRAY_0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gray_step_arbiter_cnt.sv
// gray_step_cnt3
// 3-bit Gray-code step counter with sticky overflow.
// Ports:
//   Clk      in   clock, posedge
//   Reset    in   synchronous active-high reset
//   Clr      in   synchronous clear (counter and Overflow to 0)
//   En       in   advance one step along the Gray sequence
//   Output   out  [2:0] current Gray value
//   Overflow out  sticky flag, set on the GRAY_WRAP -> GRAY_0 step
// Reset and Clr both win over En.
module gray_step_cnt3
  import gray_step_arbiter_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Clr,
  input  logic       En,
  output logic [2:0] Output,
  output logic       Overflow
);

  logic [2:0] r_gray;
  logic       r_ovf;

  always_ff @(posedge Clk) begin
    if (Reset || Clr) begin
      r_gray <= GRAY_0;
      r_ovf  <= 1'b0;
    end else if (En) begin
      r_gray <= gray_next(r_gray);
      if (r_gray == GRAY_WRAP) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign Output   = r_gray;
  assign Overflow = r_ovf;

endmodule

// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter
// Round-robin owner of a shared 3-bit Gray step counter. A granted
// requester gets its Steps value latched; the counter is optionally
// cleared, then stepped exactly that many times, then Done pulses.
// Ports:
//   Clk, Reset         clock / synchronous active-high reset
//   Req0, Steps0       requester 0 level request and step count
//   Req1, Steps1       requester 1 level request and step count
//   Grant0, Grant1     owner indication (CLEAR, RUN, DONE)
//   Done0, Done1       one-cycle completion pulse to the owner
//   Busy               FSM not in IDLE
//   GrayOut, Overflow  counter value and sticky wrap flag
module gray_step_arbiter
  import gray_step_arbiter_pkg::*;
#(
  parameter int STEP_W       = 4,
  parameter bit CLR_ON_GRANT = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic [STEP_W-1:0] Steps0,
  input  logic              Req1,
  input  logic [STEP_W-1:0] Steps1,
  output logic              Grant0,
  output logic              Grant1,
  output logic              Done0,
  output logic              Done1,
  output logic              Busy,
  output logic [2:0]        GrayOut,
  output logic              Overflow
);

  state_t            r_state, w_state_next;
  logic              r_owner, w_owner_next;
  logic              r_prio, w_prio_next;
  logic [STEP_W-1:0] r_step_cnt, w_step_cnt_next;
  logic [1:0]        r_grant, w_grant_next;
  logic [1:0]        r_done, w_done_next;

  logic [1:0]        w_req;
  logic [STEP_W-1:0] w_steps [2];
  logic              w_clr;
  logic              w_en;

  assign w_req      = {Req1, Req0};
  assign w_steps[0] = Steps0;
  assign w_steps[1] = Steps1;

  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_prio_next     = r_prio;
    w_step_cnt_next = r_step_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req != 2'b00) begin
          // Contention resolved by Prio; a lone request simply wins.
          w_owner_next    = (w_req == 2'b11) ? r_prio : w_req[1];
          w_step_cnt_next = w_steps[w_owner_next];
          if (w_step_cnt_next == '0) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = CLR_ON_GRANT ? ST_CLEAR : ST_RUN;
          end
        end
      end
      ST_CLEAR: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_step_cnt_next = r_step_cnt - STEP_W'(1);
        if (r_step_cnt == STEP_W'(1)) begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        // DONE: hand priority to the other requester for fairness.
        w_prio_next  = ~r_owner;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Grant/Done are registered from the next-state view so they line up
  // exactly with the state they describe.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign w_grant_next[gi] = (w_state_next != ST_IDLE) && (w_owner_next == 1'(gi));
      assign w_done_next[gi]  = (w_state_next == ST_DONE) && (w_owner_next == 1'(gi));
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_prio     <= 1'b0;
      r_step_cnt <= '0;
      r_grant    <= 2'b00;
      r_done     <= 2'b00;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_prio     <= w_prio_next;
      r_step_cnt <= w_step_cnt_next;
      r_grant    <= w_grant_next;
      r_done     <= w_done_next;
    end
  end

  assign w_clr = (r_state == ST_CLEAR);
  assign w_en  = (r_state == ST_RUN);

  gray_step_cnt3 u_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clr      (w_clr),
    .En       (w_en),
    .Output   (GrayOut),
    .Overflow (Overflow)
  );

  assign Grant0 = r_grant[0];
  assign Grant1 = r_grant[1];
  assign Done0  = r_done[0];
  assign Done1  = r_done[1];
  assign Busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gray_step_arbiter.sv
// tb_gray_step_arbiter
// Two instances: dut_a clears on grant, dut_b keeps counting across jobs.
// Drivers push the hand-computed job result into a per-instance queue;
// per-instance monitors pop and compare on every Done pulse.
module tb_gray_step_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, req_a0, req_a1, ga0, ga1, da0, da1, busy_a, ovf_a;
  logic [3:0] steps_a0, steps_a1;
  logic [2:0] gray_a;
  logic       rst_b, req_b0, req_b1, gb0, gb1, db0, db1, busy_b, ovf_b;
  logic [3:0] steps_b0, steps_b1;
  logic [2:0] gray_b;

  gray_step_arbiter #(.STEP_W(4), .CLR_ON_GRANT(1'b1)) dut_a (
    .Clk(clk), .Reset(rst_a), .Req0(req_a0), .Steps0(steps_a0),
    .Req1(req_a1), .Steps1(steps_a1), .Grant0(ga0), .Grant1(ga1),
    .Done0(da0), .Done1(da1), .Busy(busy_a), .GrayOut(gray_a), .Overflow(ovf_a)
  );

  gray_step_arbiter #(.STEP_W(4), .CLR_ON_GRANT(1'b0)) dut_b (
    .Clk(clk), .Reset(rst_b), .Req0(req_b0), .Steps0(steps_b0),
    .Req1(req_b1), .Steps1(steps_b1), .Grant0(gb0), .Grant1(gb1),
    .Done0(db0), .Done1(db1), .Busy(busy_b), .GrayOut(gray_b), .Overflow(ovf_b)
  );

  typedef struct {
    logic       who;
    logic [2:0] gray;
    logic       ovf;
    int         gcyc;   // cycles Grant is high, up to and including Done
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;
  int   total = 0;
  int   bad = 0;
  int   gcnt_a = 0;
  int   gcnt_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic grant_any(input bit d);
    return d ? (gb0 | gb1) : (ga0 | ga1);
  endfunction
  function automatic logic done_any(input bit d);
    return d ? (db0 | db1) : (da0 | da1);
  endfunction
  function automatic logic busy_of(input bit d);
    return d ? busy_b : busy_a;
  endfunction

  // Monitor for dut_a
  always @(negedge clk) begin
    chk("a_one_grant", {31'd0, ga0 & ga1}, 0);
    if (ga0 | ga1) gcnt_a++; else gcnt_a = 0;
    if (da0 | da1) begin
      if (sb_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_done: got done=%b%b expected none", da1, da0);
      end else begin
        ea = sb_a.pop_front();
        $display("a job: owner=%0d gray=%b ovf=%b gcyc=%0d", da1, gray_a, ovf_a, gcnt_a);
        chk("a_done_owner", {30'd0, da1, da0}, ea.who ? 2 : 1);
        chk("a_grant_owner", {31'd0, ea.who ? ga1 : ga0}, 1);
        chk("a_gray", {29'd0, gray_a}, {29'd0, ea.gray});
        chk("a_ovf", {31'd0, ovf_a}, {31'd0, ea.ovf});
        chk("a_grant_cycles", gcnt_a, ea.gcyc);
      end
    end
  end

  // Monitor for dut_b
  always @(negedge clk) begin
    chk("b_one_grant", {31'd0, gb0 & gb1}, 0);
    if (gb0 | gb1) gcnt_b++; else gcnt_b = 0;
    if (db0 | db1) begin
      if (sb_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_done: got done=%b%b expected none", db1, db0);
      end else begin
        eb = sb_b.pop_front();
        $display("b job: owner=%0d gray=%b ovf=%b gcyc=%0d", db1, gray_b, ovf_b, gcnt_b);
        chk("b_done_owner", {30'd0, db1, db0}, eb.who ? 2 : 1);
        chk("b_grant_owner", {31'd0, eb.who ? gb1 : gb0}, 1);
        chk("b_gray", {29'd0, gray_b}, {29'd0, eb.gray});
        chk("b_ovf", {31'd0, ovf_b}, {31'd0, eb.ovf});
        chk("b_grant_cycles", gcnt_b, eb.gcyc);
      end
    end
  end

  // One job on instance d by requester who; request dropped and Steps
  // scrambled as soon as the grant is seen.
  task automatic job(input bit d, input bit who, input int n,
                     input logic [2:0] g, input bit ov, input int gc);
    exp_t e;
    int   k;
    e.who = who; e.gray = g; e.ovf = ov; e.gcyc = gc;
    if (d) sb_b.push_back(e); else sb_a.push_back(e);
    if (!d && !who) begin req_a0 = 1'b1; steps_a0 = 4'(n); end
    if (!d &&  who) begin req_a1 = 1'b1; steps_a1 = 4'(n); end
    if ( d && !who) begin req_b0 = 1'b1; steps_b0 = 4'(n); end
    if ( d &&  who) begin req_b1 = 1'b1; steps_b1 = 4'(n); end
    k = 0;
    while (!grant_any(d) && k < 20) begin @(negedge clk); k++; end
    chk("job_grant_seen", {31'd0, grant_any(d)}, 1);
    req_a0 = 1'b0; req_a1 = 1'b0; req_b0 = 1'b0; req_b1 = 1'b0;
    steps_a0 = 4'hF; steps_a1 = 4'hF; steps_b0 = 4'hF; steps_b1 = 4'hF;
    k = 0;
    while (!done_any(d) && k < 40) begin @(negedge clk); k++; end
    chk("job_done_seen", {31'd0, done_any(d)}, 1);
    @(negedge clk);
    chk("job_busy_after_done", {31'd0, busy_of(d)}, 0);
  endtask

  initial begin
    int   nd;
    exp_t e;
    rst_a = 1'b1; rst_b = 1'b1;
    req_a0 = 1'b0; req_a1 = 1'b0; steps_a0 = '0; steps_a1 = '0;
    req_b0 = 1'b0; req_b1 = 1'b0; steps_b0 = '0; steps_b1 = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_grant", {30'd0, ga1, ga0}, 0);
    chk("rst_done", {30'd0, da1, da0}, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_gray", {29'd0, gray_a}, 0);
    chk("rst_ovf", {31'd0, ovf_a}, 0);
    chk("rst_b_gray", {29'd0, gray_b}, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // 3 steps after clear: 001,011,010; grant CLEAR+3 RUN+DONE = 5
    job(1'b0, 1'b0, 3, 3'b010, 1'b0, 5);
    // 9 steps: wraps through 100 -> 000 on step 8, ends at 001
    job(1'b0, 1'b1, 9, 3'b001, 1'b1, 11);
    // zero steps: Grant and Done together, counter untouched
    job(1'b0, 1'b0, 0, 3'b001, 1'b1, 1);

    // Fairness: both held, 2 steps each, order 0,1,0,1
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.who = 1'(i % 2); e.gray = 3'b011; e.ovf = 1'b0; e.gcyc = 4;
      sb_a.push_back(e);
    end
    steps_a0 = 4'd2; steps_a1 = 4'd2; req_a0 = 1'b1; req_a1 = 1'b1;
    nd = 0;
    for (int k = 0; k < 100 && nd < 4; k++) begin
      @(negedge clk);
      if (da0 | da1) nd++;
    end
    req_a0 = 1'b0; req_a1 = 1'b0;
    chk("rr_jobs_done", nd, 4);
    repeat (3) @(negedge clk);

    // Reset during the 3rd RUN cycle of a 5-step job
    steps_a0 = 4'd5; req_a0 = 1'b1;
    nd = 0;
    while (!ga0 && nd < 20) begin @(negedge clk); nd++; end
    chk("abort_grant_seen", {31'd0, ga0}, 1);
    req_a0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_gray_mid", {29'd0, gray_a}, 3'b011);
    chk("abort_busy_mid", {31'd0, busy_a}, 1);
    rst_a = 1'b1;
    @(negedge clk);
    $display("a abort: gray=%b ovf=%b grant0=%b busy=%b", gray_a, ovf_a, ga0, busy_a);
    chk("abort_gray", {29'd0, gray_a}, 0);
    chk("abort_ovf", {31'd0, ovf_a}, 0);
    chk("abort_grant0", {31'd0, ga0}, 0);
    chk("abort_busy", {31'd0, busy_a}, 0);
    rst_a = 1'b0;
    repeat (10) @(negedge clk);

    // No clear on grant: counting continues across jobs
    job(1'b1, 1'b0, 3, 3'b010, 1'b0, 4);
    job(1'b1, 1'b0, 3, 3'b101, 1'b0, 4);
    job(1'b1, 1'b0, 3, 3'b001, 1'b1, 4);

    repeat (3) @(negedge clk);
    chk("a_sb_empty", sb_a.size(), 0);
    chk("b_sb_empty", sb_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_step_arbiter.md
Name: gray_step_arbiter

Overview:
- Shares one 3-bit Gray-code step counter between two requesters.
- Each requester asks for N counter steps.
- The block arbitrates round-robin, clears the counter (optional), and pulses En for exactly N cycles. It then signals Done to the owner.
- Sits between control logic and the Gray counter datapath; the counter lives inside as a sub-module.

Parameters:
STEP_W, 4, width of the Steps0/Steps1 step-count inputs (max job = 2^STEP_W-1 steps)
CLR_ON_GRANT, 1, 1 = clear counter to 3'b000 and Overflow to 0 at start of each job; 0 = counter continues from its current value

Ports:
Clk  input  1  clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
Req0  input  1  requester 0 job request (level)
Steps0  input  STEP_W  requester 0 step count, sampled on grant
Req1  input  1  requester 1 job request (level)
Steps1  input  STEP_W  requester 1 step count, sampled on grant
Grant0  output  1  requester 0 owns the counter
Grant1  output  1  requester 1 owns the counter
Done0  output  1  one-cycle pulse, requester 0 job complete
Done1  output  1  one-cycle pulse, requester 1 job complete
Busy  output  1  state != IDLE
GrayOut  output  3  current Gray counter value
Overflow  output  1  sticky, set on 3'b100->3'b000 wrap

Behaviour:
- Reset values: Grant0=Grant1=0, Done0=Done1=0, Busy=0, GrayOut=3'b000, Overflow=0, state IDLE, Prio=0.
- Gray sequence on each enabled step: 000->001->011->010->110->111->101->100->000.
- The wrap 100->000 sets Overflow. Overflow stays set until Reset or a CLEAR cycle.
- FSM states: IDLE, CLEAR, RUN, DONE. Registered outputs; Grant_i is high in CLEAR, RUN and DONE for the owner.
- IDLE:
  - If neither Req is set, stay.
  - If only one Req is set, that requester wins.
  - If both are set, Prio selects the winner (0 -> requester 0, 1 -> requester 1).
  - Latch the winner's Steps into StepCnt and record Owner.
  - Steps==0 -> DONE directly; no clear, no counter step.
  - Otherwise -> CLEAR if CLR_ON_GRANT=1, else -> RUN.
- CLEAR: counter Clr asserted for one cycle (GrayOut->000, Overflow->0) -> RUN.
- RUN:
  - Counter En=1 every cycle; StepCnt decrements.
  - When StepCnt==1, next state is DONE.
  - Exactly N steps are taken.
- DONE:
  - Done_Owner=1 for this single cycle; Grant still high.
  - Prio <= ~Owner -> IDLE. Grant drops on the next cycle.
- Latency with CLR_ON_GRANT=1:
  - Req sampled high at edge t -> Grant at t+1.
  - CLEAR occupies t+1, RUN occupies t+2..t+1+N, Done at t+2+N.
  - Final GrayOut = seq[N mod 8].
- With CLR_ON_GRANT=0: no CLEAR cycle, so every latency above shifts 1 earlier.
- Steps and Req changes during a job are ignored; the job always completes once granted.
- A requester holding Req through DONE is re-arbitrated in the next IDLE. If the other is requesting, the other wins (fairness).
- Minimum gap between jobs: one IDLE cycle.
- Reset mid-job: on the next edge all outputs are at reset values and state is IDLE. No Done is issued for the aborted job, and Prio returns to 0.
- StepCnt is STEP_W bits wide and never underflows (Steps==0 is handled in IDLE).

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/CLEAR/RUN/DONE, 2 bits).
  - Gray sequence constants GRAY_0..GRAY_7.
  - Wrap value 3'b100.
- One sub-module, gray_step_cnt3: ports Clk, Reset, Clr, En, Output[2:0], Overflow.
  - Implements the Gray sequence and the sticky overflow.
  - Reset and Clr take priority over En.

Test Plan:
1. Reset, then Req0=1, Steps0=3 (CLR_ON_GRANT=1) -> Grant0 at cycle 1, CLEAR at 1, GrayOut 001/011/010 after RUN edges 2-4, Done0 pulse in cycle 5, Overflow=0, Busy low at 6.
2. Req1=1, Steps1=9 -> GrayOut passes 100 then 000 on step 8, Overflow=1 from then on, final GrayOut=001, Done1 pulse once.
3. Req0 and Req1 both held high after reset with Steps=2 each -> grant order 0,1,0,1, one IDLE cycle between jobs, never both Grants high.
4. Req0=1, Steps0=0 -> Grant0 and Done0 high together for exactly one cycle, GrayOut and Overflow unchanged.
5. Job of 5 steps, assert Reset during the 3rd RUN cycle -> next cycle GrayOut=000, Overflow=0, Grant0=0, Busy=0, no Done0 ever issued.
6. CLR_ON_GRANT=0: two jobs of 3 steps from reset -> first ends at 010, second continues 110/111/101, Grant-to-Done = N+1 cycles.
